// File: rtl/count_monitor_if.sv
// Observation bus between a modulo up-counter and its sequence monitor.
interface count_monitor_if #(
  parameter int MAX_COUNT = 8
);
  localparam int CNT_W = $clog2(MAX_COUNT);

  logic             enable;
  logic [CNT_W-1:0] count_in;
  logic             locked;
  logic             error;
  logic [7:0]       err_count;
  logic [7:0]       wrap_count;
  logic [CNT_W-1:0] expected;

  modport master (
    output enable, count_in,
    input  locked, error, err_count, wrap_count, expected
  );

  modport slave (
    input  enable, count_in,
    output locked, error, err_count, wrap_count, expected
  );
endinterface

// File: rtl/count_monitor.sv
// Watches a modulo-MAX_COUNT up-counter, locks onto its sequence and
// reports mismatches, verified wraps and the next expected value.
module count_monitor #(
  parameter int MAX_COUNT = 8
) (
  input  logic           clk,
  input  logic           rst,
  count_monitor_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_COUNT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_COUNT - 1);
  localparam logic [CNT_W:0]   LIMIT = (CNT_W + 1)'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           state_q;
  logic             locked_q;
  logic             error_q;
  logic [7:0]       err_count_q;
  logic [7:0]       wrap_count_q;
  logic [CNT_W-1:0] expected_q;

  logic             in_range_s;
  logic             match_s;
  logic [CNT_W-1:0] next_d;
  logic [7:0]       err_count_d;
  logic [7:0]       wrap_count_d;

  // Out-of-range samples can never match and are never used as a sync seed.
  assign in_range_s   = ({1'b0, bus.count_in} < LIMIT);
  assign match_s      = in_range_s && (bus.count_in == expected_q);
  assign next_d       = (bus.count_in == LAST) ? CNT_W'(0) : bus.count_in + CNT_W'(1);
  assign err_count_d  = (err_count_q == 8'd255) ? 8'd255 : err_count_q + 8'd1;
  assign wrap_count_d = wrap_count_q + 8'd1;

  // Monitor FSM; every output is a register updated only on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      err_count_q  <= 8'd0;
      wrap_count_q <= 8'd0;
      expected_q   <= CNT_W'(0);
    end else begin
      error_q <= 1'b0;
      if (bus.enable) begin
        case (state_q)
          IDLE, FAULT: begin
            if (in_range_s) begin
              expected_q <= next_d;
              state_q    <= SYNC;
            end
          end
          SYNC: begin
            if (match_s) begin
              expected_q <= next_d;
              locked_q   <= 1'b1;
              state_q    <= LOCKED;
            end else if (in_range_s) begin
              expected_q <= next_d;
            end
          end
          LOCKED: begin
            if (match_s) begin
              expected_q <= next_d;
              if (bus.count_in == LAST) begin
                wrap_count_q <= wrap_count_d;
              end
            end else begin
              // Keep the old expectation so the fault is visible on the bus.
              error_q     <= 1'b1;
              err_count_q <= err_count_d;
              locked_q    <= 1'b0;
              state_q     <= FAULT;
            end
          end
          default: begin
            locked_q <= 1'b0;
            state_q  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.error      = error_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;
  assign bus.expected   = expected_q;
endmodule

// File: tb/tb_count_monitor.sv
// Table-driven scoreboard bench for count_monitor at MAX_COUNT=8 and MAX_COUNT=6.
module tb_count_monitor;
  logic clk;
  logic rst;

  count_monitor_if #(.MAX_COUNT(8)) if8 ();
  count_monitor_if #(.MAX_COUNT(6)) if6 ();

  count_monitor #(.MAX_COUNT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  count_monitor #(.MAX_COUNT(6)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));

  typedef struct {
    bit         dut;     // 0: MAX_COUNT=8 instance, 1: MAX_COUNT=6 instance
    bit         en;
    logic [2:0] cnt;
    bit         locked;
    bit         error;
    int         errc;
    int         wrap;
    int         expv;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(bit d, bit en, int cnt, bit lk, bit er, int ec, int wc, int ev);
    vec_t v;
    v.dut = d; v.en = en; v.cnt = 3'(cnt);
    v.locked = lk; v.error = er; v.errc = ec; v.wrap = wc; v.expv = ev;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(vec_t v);
    if (v.dut) begin
      check("dut6.locked", int'(if6.locked), int'(v.locked));
      check("dut6.error", int'(if6.error), int'(v.error));
      check("dut6.err_count", int'(if6.err_count), v.errc);
      check("dut6.wrap_count", int'(if6.wrap_count), v.wrap);
      check("dut6.expected", int'(if6.expected), v.expv);
    end else begin
      check("dut8.locked", int'(if8.locked), int'(v.locked));
      check("dut8.error", int'(if8.error), int'(v.error));
      check("dut8.err_count", int'(if8.err_count), v.errc);
      check("dut8.wrap_count", int'(if8.wrap_count), v.wrap);
      check("dut8.expected", int'(if8.expected), v.expv);
    end
  endtask

  task automatic step(vec_t v);
    @(negedge clk);
    if8.enable   = (v.dut == 1'b0) ? v.en : 1'b0;
    if8.count_in = v.cnt;
    if6.enable   = (v.dut == 1'b1) ? v.en : 1'b0;
    if6.count_in = v.cnt;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    compare(sb_q.pop_front());
  endtask

  task automatic check_cleared(string tag);
    compare(mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0));
    compare(mk(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0));
    if (tag.len() == 0) $display("empty tag");
  endtask

  initial begin
    int errc_m;
    int wrap_m;
    int v_m;
    int nv_m;

    rst = 1'b1;
    if8.enable = 1'b1; if8.count_in = 3'd0;
    if6.enable = 1'b1; if6.count_in = 3'd0;

    // Reset held with enable high and a toggling count: everything stays clear.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if8.count_in = 3'(i + 1);
      if6.count_in = 3'(i + 2);
      @(posedge clk);
      #1;
      check_cleared("reset_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    if8.enable = 1'b0;
    if6.enable = 1'b0;

    //             dut en cnt  lk er ec wc exp
    tbl.push_back(mk(0, 1, 0,  0, 0, 0, 0, 1));   // IDLE -> SYNC
    tbl.push_back(mk(0, 1, 1,  1, 0, 0, 0, 2));   // SYNC -> LOCKED
    tbl.push_back(mk(0, 1, 2,  1, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 3,  1, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 4,  1, 0, 0, 0, 5));
    tbl.push_back(mk(0, 1, 5,  1, 0, 0, 0, 6));
    tbl.push_back(mk(0, 1, 6,  1, 0, 0, 0, 7));
    tbl.push_back(mk(0, 1, 7,  1, 0, 0, 1, 0));   // verified wrap
    tbl.push_back(mk(0, 1, 0,  1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1,  1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 1, 2,  1, 0, 0, 1, 3));
    tbl.push_back(mk(0, 1, 3,  1, 0, 0, 1, 4));
    tbl.push_back(mk(0, 1, 6,  0, 1, 1, 1, 4));   // mismatch, expected held
    tbl.push_back(mk(0, 1, 7,  0, 0, 1, 1, 0));   // FAULT -> SYNC
    tbl.push_back(mk(0, 1, 0,  1, 0, 1, 1, 1));   // SYNC -> LOCKED
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 3, 1, 0, 1, 1, 1));  // enable low: hold
    tbl.push_back(mk(0, 1, 1,  1, 0, 1, 1, 2));
    tbl.push_back(mk(0, 1, 5,  0, 1, 2, 1, 2));   // second fault
    tbl.push_back(mk(0, 1, 3,  0, 0, 2, 1, 4));   // error lasts one cycle
    tbl.push_back(mk(0, 1, 6,  0, 0, 2, 1, 7));   // SYNC mismatch recaptures
    tbl.push_back(mk(0, 1, 7,  1, 0, 2, 1, 0));   // 7 in SYNC is not a wrap
    tbl.push_back(mk(0, 1, 0,  1, 0, 2, 1, 1));
    tbl.push_back(mk(1, 1, 6,  0, 0, 0, 0, 0));   // out of range, stay IDLE
    tbl.push_back(mk(1, 1, 7,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5,  0, 0, 0, 0, 0));   // IDLE -> SYNC, next(5)=0
    tbl.push_back(mk(1, 1, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1,  1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 1, 2,  1, 0, 0, 0, 3));
    tbl.push_back(mk(1, 1, 3,  1, 0, 0, 0, 4));
    tbl.push_back(mk(1, 1, 4,  1, 0, 0, 0, 5));
    tbl.push_back(mk(1, 1, 5,  1, 0, 0, 1, 0));   // wrap at MAX_COUNT-1 = 5
    tbl.push_back(mk(1, 1, 7,  0, 1, 1, 1, 0));   // out of range while locked
    tbl.push_back(mk(1, 1, 7,  0, 0, 1, 1, 0));   // stays FAULT, no pulse
    tbl.push_back(mk(1, 1, 6,  0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 2,  0, 0, 1, 1, 3));   // FAULT -> SYNC
    tbl.push_back(mk(1, 1, 3,  1, 0, 1, 1, 4));

    foreach (tbl[i]) step(tbl[i]);

    // Mid-operation asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_cleared("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if8.enable = 1'b1; if8.count_in = 3'(i * 3);
      if6.enable = 1'b1; if6.count_in = 3'(i + 1);
      @(posedge clk);
      #1;
      check_cleared("reset_hold2");
    end
    @(negedge clk);
    rst = 1'b0;
    if8.enable = 1'b0;
    if6.enable = 1'b0;

    step(mk(0, 1, 0, 0, 0, 0, 0, 1));
    step(mk(0, 1, 1, 1, 0, 0, 0, 2));

    // err_count saturation: 256 fault/resync/lock rounds.
    for (int i = 1; i <= 256; i++) begin
      errc_m = (i > 255) ? 255 : i;
      step(mk(0, 1, 0, 0, 1, errc_m, 0, 2));
      step(mk(0, 1, 0, 0, 0, errc_m, 0, 1));
      step(mk(0, 1, 1, 1, 0, errc_m, 0, 2));
    end

    // wrap_count rolls through 255 back to 0 over 256 wraps.
    wrap_m = 0;
    v_m = 2;
    for (int k = 0; k < 2046; k++) begin
      nv_m = (v_m == 7) ? 0 : v_m + 1;
      if (v_m == 7) wrap_m = (wrap_m + 1) % 256;
      step(mk(0, 1, v_m, 1, 0, 255, wrap_m, nv_m));
      v_m = nv_m;
    end
    check("wrap_roll_final", int'(if8.wrap_count), 0);
    check("errc_sat_final", int'(if8.err_count), 255);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 8, the modulus of the observed up-counter (values 0..MAX_COUNT-1, MAX_COUNT >= 2).
REQ-002 SHALL have derived localparam CNT_W = $clog2(MAX_COUNT), default 3, the width of the observed count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  same enable that drives the counter; high marks a cycle in which the counter advances.
REQ-006 SHALL have port count_in  input  CNT_W  registered count value from the counter under observation.
REQ-007 SHALL have port locked  output  1  high while state is LOCKED.
REQ-008 SHALL have port error  output  1  one-cycle pulse on a detected sequence mismatch.
REQ-009 SHALL have port err_count  output  8  number of mismatches, saturating at 255.
REQ-010 SHALL have port wrap_count  output  8  number of verified wraps, modulo 256.
REQ-011 SHALL have port expected  output  CNT_W  value the next enabled sample must match.

Function
REQ-012 SHALL implement an FSM with states IDLE, SYNC, LOCKED and FAULT, all outputs registered.
REQ-013 SHALL sample count_in only on rising edges where enable=1; on edges with enable=0, state, expected and all counters hold, and error=0.
REQ-014 SHALL define next(v) = 0 if v == MAX_COUNT-1, else v+1, computed at CNT_W width.
REQ-015 IDLE: on an enabled edge, SHALL capture expected <= next(count_in) and go to SYNC.
REQ-016 SYNC: on an enabled edge with count_in == expected, SHALL set expected <= next(count_in) and go to LOCKED.
REQ-017 SYNC: on a mismatch, SHALL recapture expected <= next(count_in), stay in SYNC, and keep error low and err_count unchanged.
REQ-018 LOCKED: on a match, SHALL set expected <= next(count_in); if count_in == MAX_COUNT-1, wrap_count SHALL increment on that edge.
REQ-019 LOCKED: on a mismatch, SHALL assert error for exactly the next cycle, increment err_count (saturating), leave expected unchanged, and go to FAULT.
REQ-020 FAULT: on an enabled edge, SHALL capture expected <= next(count_in) and go to SYNC, with no further error pulse.
REQ-021 SHALL treat any count_in >= MAX_COUNT as a mismatch in every state, and SHALL NOT capture it as a sync seed in IDLE or FAULT (stay in the current state).
REQ-022 SHALL deassert locked on the edge that leaves LOCKED and assert it on the edge that enters LOCKED.
REQ-023 When err_count is 255, SHALL still pulse error on a mismatch while err_count stays 255; wrap_count SHALL roll from 255 to 0.

Reset
REQ-024 While rst=1, SHALL immediately force state=IDLE, locked=0, error=0, err_count=0, wrap_count=0 and expected=0, without waiting for a clock edge.
REQ-025 After rst deasserts, the first enabled edge SHALL be treated per REQ-015; rst asserted mid-operation SHALL discard lock and all counts.

Verification
REQ-026 Reset: hold rst=1 with enable=1 and count_in toggling -> all outputs 0 and state IDLE throughout.
REQ-027 Lock: MAX_COUNT=8, rst released, enable=1, count_in 0,1,2 on successive edges -> expected=1 then 2, locked=1 after the 2nd enabled edge, error=0.
REQ-028 Wrap: locked, count_in 5,6,7,0,1 -> wrap_count increments by 1 on the edge that samples 7, and locked stays 1.
REQ-029 Fault and resync: locked with expected=4, inject count_in=6 -> single-cycle error, err_count=1, locked=0; then 7,0 -> SYNC then LOCKED with expected=1.
REQ-030 Enable hold: locked, enable=0 for 5 cycles with count_in held or garbage (e.g. 3) -> no state, expected, or counter change, and no error.
REQ-031 Out-of-range and mid-op reset: MAX_COUNT=6, CNT_W=3, count_in=7 while locked -> error and FAULT; asserting rst asynchronously between edges -> outputs clear before the next edge.
